// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for the in-order pipeline.
// Tracks multi-cycle results with a per-register countdown scoreboard.
module hazard_fwd_ctrl #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int MC_LAT     = 4,
  localparam int SEL_W     = $clog2(FWD_STAGES+1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]    id_rs_addr,
  input  logic [NUM_SRC-1:0]           id_rs_used,
  input  logic [REG_AW-1:0]            id_rd_addr,
  input  logic                         id_rd_we,
  input  logic                         id_is_mc,
  input  logic [REG_AW-1:0]            ex_rd_addr,
  input  logic                         ex_rd_we,
  input  logic                         ex_mem_rd,
  input  logic [FWD_STAGES*REG_AW-1:0] fwd_rd_addr,
  input  logic [FWD_STAGES-1:0]        fwd_rd_we,
  input  logic                         flush,
  output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
  output logic                         stall,
  output logic                         bubble,
  output logic                         mc_busy,
  output logic [15:0]                  stall_cnt
);

  localparam int CW   = $clog2(MC_LAT+1);
  localparam int NREG = 1 << REG_AW;

  logic [REG_AW-1:0] rs    [NUM_SRC];
  logic [NUM_SRC-1:0] rs_ok;
  logic [CW-1:0] sb_cnt [NREG];
  logic [CW-1:0] sb_nxt [NREG];
  logic busy_nxt;
  logic load_use, sb_raw, sb_waw;
  logic mc_struct, issue, alloc;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign rs[i]    = id_rs_addr[i*REG_AW +: REG_AW];
    assign rs_ok[i] = id_rs_used[i] && (rs[i] != '0);
  end

  // Walk furthest to nearest so the nearest match wins.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_STAGES-1; k >= 0; k--) begin
        if (rs_ok[i] && fwd_rd_we[k] &&
            fwd_rd_addr[k*REG_AW +: REG_AW] == rs[i])
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k+1);
      end
    end
  end

  always_comb begin
    load_use = 1'b0;
    sb_raw   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_ok[i]) begin
        if (ex_mem_rd && ex_rd_we && ex_rd_addr != '0 &&
            ex_rd_addr == rs[i])
          load_use = 1'b1;
        if (sb_cnt[rs[i]] != '0)
          sb_raw = 1'b1;
      end
    end
  end

  assign sb_waw = id_rd_we && (id_rd_addr != '0) &&
                  (sb_cnt[id_rd_addr] != '0);
  assign mc_struct = id_is_mc && mc_busy;

  assign stall  = id_valid && !flush &&
                  (load_use || sb_raw || sb_waw || mc_struct);
  assign bubble = stall || flush;
  assign issue  = id_valid && !stall && !flush;
  assign alloc  = issue && id_is_mc && id_rd_we &&
                  (id_rd_addr != '0);

  // Load takes precedence over the decrement of the same entry.
  always_comb begin
    busy_nxt = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      sb_nxt[r] = (sb_cnt[r] != '0) ? sb_cnt[r] - CW'(1) : '0;
      if (alloc && id_rd_addr == REG_AW'(r))
        sb_nxt[r] = CW'(MC_LAT);
      if (sb_nxt[r] != '0)
        busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_cnt    <= '{default: '0};
      mc_busy   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      sb_cnt  <= sb_nxt;
      mc_busy <= busy_nxt;
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL provide parameter REG_AW, default 5: register-address width.
REQ-002 SHALL provide parameter NUM_SRC, default 2: number of source-operand read ports.
REQ-003 SHALL provide parameter FWD_STAGES, default 2: forwarding stages; index 0 is nearest (MEM), FWD_STAGES-1 is furthest (WB).
REQ-004 SHALL provide parameter MC_LAT, default 4, minimum 1: multi-cycle unit latency in cycles.
REQ-005 SHALL provide localparam SEL_W = $clog2(FWD_STAGES+1).
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port id_valid, input, 1: decode-stage instruction valid.
REQ-009 SHALL have port id_rs_addr, input, NUM_SRC*REG_AW: packed source addresses; source i is at [i*REG_AW +: REG_AW].
REQ-010 SHALL have port id_rs_used, input, NUM_SRC: bit i set means source i is actually read.
REQ-011 SHALL have ports id_rd_addr (REG_AW), id_rd_we (1) and id_is_mc (1), all inputs: decode destination, write enable, multi-cycle op flag.
REQ-012 SHALL have ports ex_rd_addr (REG_AW), ex_rd_we (1) and ex_mem_rd (1), all inputs: EX-stage destination, write enable, load flag.
REQ-013 SHALL have ports fwd_rd_addr (FWD_STAGES*REG_AW) and fwd_rd_we (FWD_STAGES), both inputs: destinations and write enables of the forwarding stages.
REQ-014 SHALL have port flush, input, 1: branch redirect; kills the decode instruction.
REQ-015 SHALL have port fwd_sel, output, NUM_SRC*SEL_W: per source, 0 means register file and k+1 means forwarding stage k.
REQ-016 SHALL have ports stall, bubble and mc_busy, outputs, 1 each; stall_cnt, output, 16.

Function
REQ-017 For each source i, fwd_sel SHALL be combinational: it SHALL select the lowest k with fwd_rd_we[k], fwd_rd_addr[k]==rs_i, rs_i!=0 and id_rs_used[i]; otherwise it SHALL be 0.
REQ-018 Address 0 SHALL never forward, never stall, and never allocate a scoreboard entry.
REQ-019 load_use SHALL be asserted when ex_mem_rd, ex_rd_we and ex_rd_addr!=0 are set and ex_rd_addr matches any used rs_i.
REQ-020 The scoreboard SHALL hold one countdown counter per register, width $clog2(MC_LAT+1).
REQ-021 sb_raw SHALL be asserted when any used, nonzero rs_i has a nonzero counter.
REQ-022 sb_waw SHALL be asserted when id_rd_we is set, id_rd_addr!=0 and the id_rd_addr counter is nonzero.
REQ-023 mc_struct SHALL be asserted when id_is_mc and mc_busy are both set.
REQ-024 stall SHALL equal id_valid & !flush & (load_use | sb_raw | sb_waw | mc_struct), combinationally.
REQ-025 bubble SHALL equal stall | flush.
REQ-026 issue SHALL equal id_valid & !stall & !flush.
REQ-027 On issue with id_is_mc, id_rd_we set and id_rd_addr!=0, the counter for id_rd_addr SHALL load MC_LAT at the clock edge.
REQ-028 All nonzero counters SHALL decrement by 1 per cycle; a counter SHALL never wrap below 0.
REQ-029 A same-cycle load and decrement of one entry SHALL resolve as a load; this cannot occur in practice because sb_waw stalls it.
REQ-030 mc_busy SHALL be registered and SHALL equal the OR of all counters being nonzero after the edge.
REQ-031 Timing: an mc op issued at edge t makes its counter MC_LAT after t; a dependent instruction SHALL stall for MC_LAT cycles and issue at the first edge where the counter reads 0.
REQ-032 flush SHALL NOT clear the scoreboard, because already-issued mc ops complete.
REQ-033 flush SHALL suppress allocation for the decode instruction and force stall=0 in the same cycle.
REQ-034 stall_cnt SHALL increment on every cycle with stall=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-035 While rst_n=0, all counters SHALL be 0, mc_busy SHALL be 0 and stall_cnt SHALL be 0, asynchronously.
REQ-036 During reset, combinational outputs SHALL follow their inputs with an empty scoreboard.
REQ-037 Reset asserted mid-countdown SHALL discard the pending entry; after release, no sb_raw stall SHALL exist for that register.

Verification
REQ-038 Forwarding priority: rs1=5, stage0 rd=5 we=1, stage1 rd=5 we=1 -> fwd_sel[0]=1; drop stage0 we -> fwd_sel[0]=2; set rs1=0 -> fwd_sel[0]=0.
REQ-039 Load-use: ex_mem_rd=1, ex_rd=7, rs2=7 used -> stall=1, bubble=1, stall_cnt +1; with id_rs_used[1]=0 -> stall=0.
REQ-040 Multi-cycle RAW: issue mc op rd=9 with MC_LAT=4, then rs1=9 -> stall high exactly 4 cycles, issue on cycle 5, stall_cnt=4.
REQ-041 Structural and WAW: second mc op while mc_busy -> stall; non-mc op with rd=9 while entry 9 pending -> stall until counter 0.
REQ-042 Flush: flush=1 with a load-use condition present -> stall=0, bubble=1, no allocation; pending entry 9 still counts down to 0.
REQ-043 Reset and saturation: rst_n low at counter=2 -> mc_busy=0 immediately, rs1=9 issues after release; force 65536+ stall cycles -> stall_cnt holds 16'hFFFF.
